// File: rtl/fp_pkg.sv
// Shared widths and FSM state encoding for the floating-point align/add datapath.
package fp_pkg;

    localparam int EXP_WIDTH_DEF      = 8;
    localparam int MANTISSA_WIDTH_DEF = 23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_ADD   = 2'd2
    } state_t;

endpackage

// File: rtl/operand_swap.sv
// Orders two packed operands by {exponent, fraction} magnitude and expands mantissas with the hidden bit.
module operand_swap
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH      = EXP_WIDTH_DEF,
    parameter int MANTISSA_WIDTH = MANTISSA_WIDTH_DEF
) (
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] i_a,
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] i_b,
    input  logic                              i_sub,
    output logic                              o_sign_l,
    output logic                              o_sign_s,
    output logic [EXP_WIDTH-1:0]              o_exp_l,
    output logic [EXP_WIDTH-1:0]              o_exp_s,
    output logic [MANTISSA_WIDTH:0]           o_man_l,
    output logic [MANTISSA_WIDTH:0]           o_man_s
);

    localparam int MSB = EXP_WIDTH + MANTISSA_WIDTH;

    logic                      w_sign_b;
    logic                      w_swap;
    logic [EXP_WIDTH-1:0]      w_exp_a;
    logic [EXP_WIDTH-1:0]      w_exp_b;
    logic [MANTISSA_WIDTH:0]   w_man_a;
    logic [MANTISSA_WIDTH:0]   w_man_b;

    // Exponent sits directly above the fraction, so the low MSB bits compare as one magnitude.
    assign w_swap   = i_b[MSB-1:0] > i_a[MSB-1:0];
    assign w_sign_b = i_b[MSB] ^ i_sub;
    assign w_exp_a  = i_a[MSB-1:MANTISSA_WIDTH];
    assign w_exp_b  = i_b[MSB-1:MANTISSA_WIDTH];
    assign w_man_a  = {|w_exp_a, i_a[MANTISSA_WIDTH-1:0]};
    assign w_man_b  = {|w_exp_b, i_b[MANTISSA_WIDTH-1:0]};

    assign o_sign_l = w_swap ? w_sign_b : i_a[MSB];
    assign o_sign_s = w_swap ? i_a[MSB] : w_sign_b;
    assign o_exp_l  = w_swap ? w_exp_b  : w_exp_a;
    assign o_exp_s  = w_swap ? w_exp_a  : w_exp_b;
    assign o_man_l  = w_swap ? w_man_b  : w_man_a;
    assign o_man_s  = w_swap ? w_man_a  : w_man_b;

endmodule

// File: rtl/align_adder.sv
// Aligns the smaller operand's mantissa and adds/subtracts, producing an unnormalized result.
// Macro ALIGN_FAST_SHIFT_EN selects a single-cycle barrel shift instead of one bit per cycle.
module align_adder
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH      = EXP_WIDTH_DEF,
    parameter int MANTISSA_WIDTH = MANTISSA_WIDTH_DEF
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              start_in,
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] a_in,
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] b_in,
    input  logic                              sub_in,
    output logic                              busy_out,
    output logic                              done_out,
    output logic                              sign_out,
    output logic [EXP_WIDTH-1:0]              expoent_out,
    output logic [MANTISSA_WIDTH+1:0]         result_out
);

    localparam int MW = MANTISSA_WIDTH + 1;
    localparam int RW = MANTISSA_WIDTH + 2;
    localparam int CW = $clog2(RW) + 1;

    logic                 w_sign_l;
    logic                 w_sign_s;
    logic [EXP_WIDTH-1:0] w_exp_l;
    logic [EXP_WIDTH-1:0] w_exp_s;
    logic [MW-1:0]        w_man_l;
    logic [MW-1:0]        w_man_s;
    logic [EXP_WIDTH-1:0] w_d;
    logic [CW-1:0]        w_k;
    logic [RW-1:0]        w_sum;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic                 r_sign_l;
    logic                 r_sign_s;
    logic [EXP_WIDTH-1:0] r_exp_l;
    logic [MW-1:0]        r_man_l;
    logic [MW-1:0]        r_man_s;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_sign;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [RW-1:0]        r_result;

    operand_swap #(
        .EXP_WIDTH      (EXP_WIDTH),
        .MANTISSA_WIDTH (MANTISSA_WIDTH)
    ) u_swap (
        .i_a      (a_in),
        .i_b      (b_in),
        .i_sub    (sub_in),
        .o_sign_l (w_sign_l),
        .o_sign_s (w_sign_s),
        .o_exp_l  (w_exp_l),
        .o_exp_s  (w_exp_s),
        .o_man_l  (w_man_l),
        .o_man_s  (w_man_s)
    );

    assign w_d = w_exp_l - w_exp_s;

`ifdef ALIGN_FAST_SHIFT_EN
    logic [EXP_WIDTH-1:0] r_d;
    assign w_k = (w_d != '0) ? CW'(1) : '0;
`else
    logic                 r_big;
    logic                 w_big;
    // Shifts of RW or more clear every bit, so they collapse into one zeroing cycle.
    assign w_big = (int'(w_d) >= RW);
    assign w_k   = (w_d == '0) ? '0 : (w_big ? CW'(1) : CW'(w_d));
`endif

    always_comb begin
        w_sum = '0;
        if (r_sign_l == r_sign_s) begin
            w_sum = {1'b0, r_man_l} + {1'b0, r_man_s};
        end else begin
            w_sum = {1'b0, r_man_l} - {1'b0, r_man_s};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_sign_l <= 1'b0;
            r_sign_s <= 1'b0;
            r_exp_l  <= '0;
            r_man_l  <= '0;
            r_man_s  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_result <= '0;
`ifdef ALIGN_FAST_SHIFT_EN
            r_d      <= '0;
`else
            r_big    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_in) begin
                        r_sign_l <= w_sign_l;
                        r_sign_s <= w_sign_s;
                        r_exp_l  <= w_exp_l;
                        r_man_l  <= w_man_l;
                        r_man_s  <= w_man_s;
                        r_cnt    <= w_k;
                        r_busy   <= 1'b1;
`ifdef ALIGN_FAST_SHIFT_EN
                        r_d      <= w_d;
`else
                        r_big    <= w_big;
`endif
                        r_state  <= (w_k == '0) ? ST_ADD : ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
`ifdef ALIGN_FAST_SHIFT_EN
                    r_man_s <= r_man_s >> r_d;
`else
                    r_man_s <= r_big ? '0 : (r_man_s >> 1);
`endif
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    r_result <= w_sum;
                    r_exp    <= r_exp_l;
                    r_sign   <= (w_sum == '0) ? 1'b0 : r_sign_l;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_out    = r_busy;
    assign done_out    = r_done;
    assign sign_out    = r_sign;
    assign expoent_out = r_exp;
    assign result_out  = r_result;

endmodule

// File: tb/tb_align_adder.sv
// Scoreboard bench for align_adder: directed single-precision vectors plus randomized operands.
module tb_align_adder;

    localparam int EW  = 8;
    localparam int MWD = 23;
    localparam int W   = EW + MWD + 1;
    localparam int RW  = MWD + 2;

    typedef struct {
        logic          sign;
        logic [EW-1:0] e;
        logic [RW-1:0] r;
        int            cyc;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sub   = 1'b0;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic          busy;
    logic          done;
    logic          sign;
    logic [EW-1:0] expo;
    logic [RW-1:0] res;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    exp_t m_e;
    logic m_due;
    logic          h_sign = 1'b0;
    logic [EW-1:0] h_e    = '0;
    logic [RW-1:0] h_r    = '0;

    align_adder #(.EXP_WIDTH(EW), .MANTISSA_WIDTH(MWD)) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .start_in    (start),
        .a_in        (a),
        .b_in        (b),
        .sub_in      (sub),
        .busy_out    (busy),
        .done_out    (done),
        .sign_out    (sign),
        .expoent_out (expo),
        .result_out  (res)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // reference model: integer arithmetic on decoded fields
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic sv, input int now);
        exp_t   e;
        int     ea, eb, d, k;
        longint ma, mb, ml, ms, r;
        logic   sa, sb, sl, ss;
        ea = int'(av[W-2:MWD]);
        eb = int'(bv[W-2:MWD]);
        ma = longint'(av[MWD-1:0]) + ((ea != 0) ? (longint'(1) << MWD) : 0);
        mb = longint'(bv[MWD-1:0]) + ((eb != 0) ? (longint'(1) << MWD) : 0);
        sa = av[W-1];
        sb = bv[W-1] ^ sv;
        if (eb > ea || (eb == ea && mb > ma)) begin
            ml = mb; ms = ma; sl = sb; ss = sa; d = eb - ea; e.e = EW'(eb);
        end else begin
            ml = ma; ms = mb; sl = sa; ss = sb; d = ea - eb; e.e = EW'(ea);
        end
        ms = (d >= RW) ? 0 : (ms >> d);
        r  = (sl == ss) ? ml + ms : ml - ms;
        e.r    = RW'(r);
        e.sign = (r == 0) ? 1'b0 : sl;
`ifdef ALIGN_FAST_SHIFT_EN
        k = (d > 0) ? 1 : 0;
`else
        k = (d == 0) ? 0 : ((d >= RW) ? 1 : d);
`endif
        e.cyc = now + k + 2;
        return e;
    endfunction

    // monitor: samples 2 time units after each rising edge
    always begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_out", {sign, expo, res}, 0);
            exp_q.delete();
            h_sign = 1'b0; h_e = '0; h_r = '0;
        end else begin
            m_due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            check("busy", busy, (exp_q.size() > 0) && !m_due);
            check("done", done, m_due);
            if (m_due) begin
                m_e = exp_q.pop_front();
                h_sign = m_e.sign; h_e = m_e.e; h_r = m_e.r;
            end
            check("sign", sign, h_sign);
            check("expoent", expo, h_e);
            check("result", res, h_r);
        end
    end

    // driver: call at a falling edge; optionally pokes start while busy
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                         input logic use_model, input exp_t fixed, input int k);
        int   n;
        exp_t e;
        n = 0;
        while (busy && n < 100) begin
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom);
                @(negedge clk);
                start = 1'b0;
            end else begin
                @(negedge clk);
            end
            n++;
        end
        if (n >= 100) begin
            tests++; fails++;
            $display("FAIL busy_timeout: busy stuck at 1, required 0");
        end
        a = av; b = bv; sub = sv; start = 1'b1;
        if (use_model) begin
            e = model(av, bv, sv, cyc);
        end else begin
            e = fixed;
            e.cyc = cyc + k + 2;
        end
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic directed(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                            input logic s, input logic [EW-1:0] e, input logic [RW-1:0] r, input int k);
        exp_t f;
        f.sign = s; f.e = e; f.r = r; f.cyc = 0;
        issue(av, bv, sv, 1'b0, f, k);
    endtask

    initial begin
        exp_t   f;
        int     ea, eb, n, mode;
        logic [W-1:0] av, bv;

        // start held through reset: first sample on the edge after release
        a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; start = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        f.sign = 1'b0; f.e = 8'h7F; f.r = 25'h1000000; f.cyc = cyc + 2;
        exp_q.push_back(f);
        @(negedge clk);
        start = 1'b0;

        directed(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 8'h7F, 25'h1000000, 0);
        directed(32'h3F800000, 32'h3F000000, 1'b0, 1'b0, 8'h7F, 25'h0C00000, 1);
        directed(32'hC0400000, 32'h3F800000, 1'b0, 1'b1, 8'h80, 25'h0800000, 1);
        directed(32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 8'h7F, 25'h0000000, 0);
        directed(32'h3F800000, 32'h30800000, 1'b0, 1'b0, 8'h7F, 25'h0800000, 1);
        directed(32'h3F000000, 32'h3F800000, 1'b1, 1'b1, 8'h7F, 25'h0400000, 1);
        directed(32'h7F800000, 32'h7F800000, 1'b0, 1'b0, 8'hFF, 25'h1000000, 0);
`ifdef ALIGN_FAST_SHIFT_EN
        directed(32'h3F800000, 32'h3A800000, 1'b0, 1'b0, 8'h7F, 25'h0802000, 1);
`else
        directed(32'h3F800000, 32'h3A800000, 1'b0, 1'b0, 8'h7F, 25'h0802000, 10);
`endif

        for (int i = 0; i < 300; i++) begin
            av   = $urandom;
            ea   = int'(av[W-2:MWD]);
            mode = $urandom_range(0, 4);
            case (mode)
                0: bv = $urandom;
                1: begin
                    eb = ea + $urandom_range(0, 40) - 20;
                    if (eb < 0) eb = 0;
                    if (eb > 255) eb = 255;
                    bv = {1'($urandom), EW'(eb), MWD'($urandom)};
                end
                2: bv = {1'($urandom), av[W-2:0]};
                3: begin
                    av[W-2:MWD] = '0;
                    bv = {1'($urandom), EW'($urandom_range(0, 3)), MWD'($urandom)};
                end
                default: begin
                    eb = ea - $urandom_range(20, 30);
                    if (eb < 0) eb = 0;
                    bv = {1'($urandom), EW'(eb), MWD'($urandom)};
                end
            endcase
            if ($urandom_range(0, 1) == 1) issue(av, bv, 1'($urandom), 1'b1, f, 0);
            else                           issue(bv, av, 1'($urandom), 1'b1, f, 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // reset mid-ALIGN with a re-pulse of start while busy
        n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        a = 32'h3F800000; b = 32'h3A800000; sub = 1'b0; start = 1'b1;
        exp_q.push_back(model(a, b, sub, cyc));
        @(negedge clk);
`ifndef ALIGN_FAST_SHIFT_EN
        a = 32'h40000000; b = 32'h40000000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
`endif
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_out", {sign, expo, res}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);

        directed(32'hC0400000, 32'h3F800000, 1'b0, 1'b1, 8'h80, 25'h0800000, 1);

        n = 0;
        while (exp_q.size() > 0 && n < 200) begin @(negedge clk); n++; end
        if (exp_q.size() > 0) begin
            tests++; fails++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/align_adder.md
ALIGN_ADDER -- requirements
Module: align_adder

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8: exponent field width.
REQ-002 SHALL have parameter MANTISSA_WIDTH, default 23: stored fraction width.
REQ-003 SHALL have port clk_in, input, 1: single clock, all state on its rising edge.
REQ-004 SHALL have port rst_n_in, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start_in, input, 1: operands valid; sampled only in IDLE.
REQ-006 SHALL have ports a_in, b_in, input, EXP_WIDTH+MANTISSA_WIDTH+1: packed {sign, exponent, fraction}.
REQ-007 SHALL have port sub_in, input, 1: 1 computes a-b, 0 computes a+b.
REQ-008 SHALL have port busy_out, output, 1: operation in progress.
REQ-009 SHALL have port done_out, output, 1: one-cycle pulse, result valid.
REQ-010 SHALL have port sign_out, output, 1: result sign.
REQ-011 SHALL have port expoent_out, output, EXP_WIDTH: unnormalized exponent for the normalizer's expoent_in.
REQ-012 SHALL have port result_out, output, MANTISSA_WIDTH+2: carry bit plus hidden bit plus fraction, for the normalizer's result_in.

Function
REQ-013 SHALL form each mantissa as {hidden, fraction}; hidden = OR of exponent bits.
REQ-014 SHALL in IDLE on start_in latch operands, swapping so operand L has the larger {exponent, fraction} magnitude; S is the other; B's sign is inverted when sub_in=1.
REQ-015 SHALL compute d = exp(L) - exp(S); set k = 0 if d=0, k = 1 if d >= MANTISSA_WIDTH+2, else k = d.
REQ-016 SHALL use FSM states IDLE -> ALIGN (k>0) or ADD (k=0); ALIGN -> ADD after k cycles; ADD -> IDLE.
REQ-017 SHALL in ALIGN shift S mantissa right one bit per cycle; when d >= MANTISSA_WIDTH+2, SHALL zero it in a single cycle. Shifted-out bits are discarded.
REQ-018 SHALL in ADD add mantissas when effective signs are equal, otherwise subtract (L-S, never negative); the result is zero-extended to MANTISSA_WIDTH+2 bits.
REQ-019 SHALL drive expoent_out = exp(L), sign_out = effective sign of L; an exact zero result SHALL force sign_out=0.
REQ-020 SHALL register the outputs on the ADD edge and pulse done_out for exactly one cycle, k+1 cycles after the start_in sample cycle.
REQ-021 SHALL hold sign_out, expoent_out and result_out until the next ADD.
REQ-022 SHALL hold busy_out high from the start sample edge until the ADD edge.
REQ-023 SHALL ignore start_in while busy_out=1; start_in in the done_out cycle SHALL be accepted (back-to-back).
REQ-024 SHALL treat exponent all-ones as an ordinary value; no NaN/Inf detection.

Reset
REQ-025 SHALL on rst_n_in low, at any time including mid-ALIGN, force state IDLE and clear busy_out, done_out, sign_out, expoent_out, result_out and the internal registers to 0.
REQ-026 SHALL not sample start_in while in reset; the first sample occurs on the first edge after release.

Configuration
REQ-027 SHALL honour macro ALIGN_FAST_SHIFT_EN: when defined, ALIGN SHALL be a single-cycle barrel shift by d (k=1 for any d>0); when undefined, SHALL shift one bit per cycle per REQ-017.
REQ-028 SHALL produce results identical in both configurations; only latency differs.

Structure
REQ-029 SHALL take the FSM state enum typedef and the default width constants from the shared package fp_pkg.
REQ-030 SHALL place the magnitude compare and swap in a combinational sub-module operand_swap; the FSM, shifter and adder SHALL be in align_adder.

Verification (single precision; latency uses the serial configuration unless noted)
REQ-031 SHALL check a=0x3F800000, b=0x3F800000, sub=0 -> expoent_out=0x7F, result_out=0x1000000, sign 0, done 1 cycle after start.
REQ-032 SHALL check a=0x3F800000, b=0x3F000000, sub=0 -> expoent_out=0x7F, result_out=0x0C00000, done 2 cycles after start.
REQ-033 SHALL check a=0xC0400000, b=0x3F800000, sub=0 -> sign 1, expoent_out=0x80, result_out=0x0800000, done 2 cycles after start.
REQ-034 SHALL check a=b=0x3F800000, sub=1 -> result_out=0, sign 0, expoent_out=0x7F.
REQ-035 SHALL check a=0x3F800000, b=0x30800000 (d=30) -> result_out=0x0800000, done 2 cycles after start; with ALIGN_FAST_SHIFT_EN, d=10 -> done 2 cycles after start.
REQ-036 SHALL check start with d=10, start_in re-pulsed while busy, then rst_n_in low mid-ALIGN -> re-pulse ignored, all outputs 0 and busy_out 0 immediately, no done_out pulse.
